// File: rtl/i2c_cfg_sequencer_if.sv
// rtl/i2c_cfg_sequencer_if.sv - table ROM port and I2C write-controller handshake
interface i2c_cfg_sequencer_if #(parameter int TBL_AW = 8);
  logic [TBL_AW-1:0] tbl_addr;
  logic [15:0]       tbl_data;
  logic              i2c_enable;
  logic [15:0]       i2c_register_address;
  logic              i2c_register_done;

  modport master (
    output tbl_addr,
    input  tbl_data,
    output i2c_enable,
    output i2c_register_address,
    input  i2c_register_done
  );

  modport slave (
    input  tbl_addr,
    output tbl_data,
    input  i2c_enable,
    input  i2c_register_address,
    output i2c_register_done
  );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks a ROM table of 16-bit entries and issues one I2C write per entry
module i2c_cfg_sequencer #(
  parameter int TBL_AW          = 8,
  parameter int MAX_RETRY       = 3,
  parameter int TIMEOUT_STROBES = 255,
  parameter int GAP_STROBES     = 4,
  parameter int DELAY_UNIT      = 100
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              strobe_100kHz,
  input  logic              start,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [TBL_AW-1:0] err_index,
  i2c_cfg_sequencer_if.master bus
);
  localparam int TO_W    = $clog2(TIMEOUT_STROBES + 1);
  localparam int GP_W    = $clog2(GAP_STROBES + 1);
  localparam int RT_W    = $clog2(MAX_RETRY + 1);
  localparam int DLY_MIN = $clog2(255 * DELAY_UNIT + 1);
  localparam int DLY_W   = (DLY_MIN > 17) ? DLY_MIN : 17;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, ADVANCE, GAP, DELAY, DONE, ERROR
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   timeout_cnt;
  logic [GP_W-1:0]   gap_cnt;
  logic [RT_W-1:0]   retry_cnt;
  logic [DLY_W-1:0]  delay_cnt;
  logic              retrying;
  logic              done_q;
  logic              done_rise;

  // Only an edge counts: the controller's done level from the last write stays high until it takes the next enable.
  assign done_rise = bus.i2c_register_done & ~done_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) done_q <= 1'b0;
    else        done_q <= bus.i2c_register_done;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state                    <= IDLE;
      busy                     <= 1'b0;
      cfg_done                 <= 1'b0;
      cfg_error                <= 1'b0;
      err_index                <= '0;
      bus.tbl_addr             <= '0;
      bus.i2c_enable           <= 1'b0;
      bus.i2c_register_address <= '0;
      timeout_cnt              <= '0;
      gap_cnt                  <= '0;
      retry_cnt                <= '0;
      delay_cnt                <= '0;
      retrying                 <= 1'b0;
    end else begin
      bus.i2c_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            err_index    <= '0;
            bus.tbl_addr <= '0;
            retry_cnt    <= '0;
            retrying     <= 1'b0;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (bus.tbl_data == 16'hFFFF) begin
            state <= DONE;
          end else if (bus.tbl_data[15:8] == 8'hFE) begin
            if (bus.tbl_data[7:0] == 8'h00) begin
              state <= ADVANCE;
            end else begin
              delay_cnt <= DLY_W'(bus.tbl_data[7:0]) * DLY_W'(DELAY_UNIT);
              state     <= DELAY;
            end
          end else begin
            bus.i2c_register_address <= bus.tbl_data;
            bus.i2c_enable           <= 1'b1;
            state                    <= ISSUE;
          end
        end
        ISSUE: begin
          timeout_cnt <= '0;
          state       <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_rise) begin
            state <= ADVANCE;
          end else if (strobe_100kHz) begin
            if (timeout_cnt == TO_W'(TIMEOUT_STROBES - 1)) begin
              if (retry_cnt == RT_W'(MAX_RETRY)) begin
                err_index <= bus.tbl_addr;
                state     <= ERROR;
              end else begin
                retry_cnt <= retry_cnt + 1'b1;
                retrying  <= 1'b1;
                gap_cnt   <= '0;
                state     <= GAP;
              end
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
          end
        end
        ADVANCE: begin
          retry_cnt <= '0;
          retrying  <= 1'b0;
          if (bus.tbl_addr == {TBL_AW{1'b1}}) begin
            state <= DONE;
          end else begin
            bus.tbl_addr <= bus.tbl_addr + 1'b1;
            gap_cnt      <= '0;
            state        <= GAP;
          end
        end
        GAP: begin
          if (strobe_100kHz) begin
            if (gap_cnt == GP_W'(GAP_STROBES - 1)) begin
              gap_cnt <= '0;
              // A retry re-issues the held payload without refetching the entry.
              if (retrying) begin
                bus.i2c_enable <= 1'b1;
                state          <= ISSUE;
              end else begin
                state <= FETCH;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        DELAY: begin
          if (strobe_100kHz) begin
            if (delay_cnt <= DLY_W'(1)) begin
              delay_cnt <= '0;
              state     <= ADVANCE;
            end else begin
              delay_cnt <= delay_cnt - 1'b1;
            end
          end
        end
        DONE: begin
          cfg_done <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        ERROR: begin
          cfg_error <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - scoreboard bench with a table-level reference model and controller model
module tb_i2c_cfg_sequencer;
  localparam int N = 256;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       strobe_100kHz = 1'b0;
  logic       start = 1'b0;
  logic       busy, cfg_done, cfg_error;
  logic [7:0] err_index;

  i2c_cfg_sequencer_if #(.TBL_AW(8)) bus ();

  i2c_cfg_sequencer #(
    .TBL_AW(8), .MAX_RETRY(3), .TIMEOUT_STROBES(255), .GAP_STROBES(4), .DELAY_UNIT(100)
  ) dut (
    .clk(clk), .areset(areset), .strobe_100kHz(strobe_100kHz), .start(start),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .err_index(err_index),
    .bus(bus.master)
  );

  initial forever #5 clk = ~clk;

  logic [15:0] rom [N];
  always @(posedge clk) bus.tbl_data <= rom[bus.tbl_addr];

  typedef struct {
    logic [15:0] payload;
    bit          ack;
    int          resp;
    int          min_gap;
    bit          exact;
  } exp_t;

  exp_t  expq[$];
  int    fail_cnt [N];
  int    resp_d [N];
  int    total = 0, bad = 0;
  string cur_case = "init";
  bit    exp_done, exp_err;
  int    exp_idx, exp_addr;
  int    poke_at = -1;
  int    gap_cnt = 0, pend = 0, en_seen = 0;
  bit    prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s/%s: got %0h want %0h", cur_case, name, act, req);
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < N; i++) begin
      rom[i] = 16'hFFFF; fail_cnt[i] = 0; resp_d[i] = 1;
    end
  endtask

  function automatic logic [15:0] rand_payload();
    logic [7:0] hi, lo;
    hi = 8'($urandom_range(0, 8'hFD));
    lo = 8'($urandom);
    return {hi, lo};
  endfunction

  // Walk the table as a list of transactions: what enables appear, the strobe spacing they
  // must have, and how the run ends.
  task automatic build_expect();
    int gap;
    logic [15:0] d;
    exp_t e;
    gap = 0; exp_done = 0; exp_err = 0; exp_idx = 0; exp_addr = 0;
    for (int i = 0; i < N; i++) begin
      d = rom[i];
      exp_addr = i;
      if (d == 16'hFFFF) begin exp_done = 1; return; end
      if (d[15:8] == 8'hFE) begin
        gap += int'(d[7:0]) * 100;
      end else begin
        for (int a = 0; a <= 3; a++) begin
          e.payload = d; e.ack = (a >= fail_cnt[i]); e.resp = resp_d[i];
          e.min_gap = gap; e.exact = (a > 0);
          expq.push_back(e);
          if (e.ack) begin gap = resp_d[i]; break; end
          gap = 255 + 4;
        end
        if (!expq[$].ack) begin exp_err = 1; exp_idx = i; return; end
      end
      if (i == N - 1) begin exp_done = 1; return; end
      gap += 4;
    end
  endtask

  // Strobe source, I2C controller model and scoreboard monitor, all evaluated at negedge.
  initial begin
    exp_t e;
    bus.i2c_register_done = 1'b0;
    forever begin
      @(negedge clk);
      strobe_100kHz = !strobe_100kHz && ($urandom_range(0, 2) != 0);
      if (areset) begin
        pend = 0; gap_cnt = 0; prev_en = 1'b0; bus.i2c_register_done = 1'b0;
      end else begin
        if (start && !busy) gap_cnt = 0;
        if (bus.i2c_enable) begin
          en_seen++;
          check("enable_pulse_width", {31'd0, prev_en}, 0);
          check("enable_expected", {31'd0, expq.size() != 0}, 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            check("payload", bus.i2c_register_address, e.payload);
            if (e.exact) check("retry_gap", gap_cnt, e.min_gap);
            else         check("gap_min", {31'd0, gap_cnt >= e.min_gap}, 1);
            if (e.ack) begin bus.i2c_register_done = 1'b0; pend = e.resp; end
            else pend = 0;
          end
          gap_cnt = 0;
        end else if (strobe_100kHz) begin
          gap_cnt++;
          if (pend > 0) begin
            pend--;
            if (pend == 0) bus.i2c_register_done = 1'b1;
          end
        end
        prev_en = bus.i2c_enable;
      end
    end
  end

  task automatic reset_check();
    #2 areset = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_enable", {31'd0, bus.i2c_enable}, 0);
    check("rst_reg_addr", bus.i2c_register_address, 0);
    check("rst_tbl_addr", bus.tbl_addr, 0);
    check("rst_cfg_done", {31'd0, cfg_done}, 0);
    check("rst_cfg_error", {31'd0, cfg_error}, 0);
    check("rst_err_index", err_index, 0);
    expq.delete();
    @(posedge clk); #1 areset = 1'b0;
  endtask

  task automatic start_seq();
    expq.delete();
    build_expect();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_seq(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      start = (n == poke_at);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    poke_at = -1;
    check("finish_in_budget", {31'd0, n < budget}, 1);
    check("busy_low", {31'd0, busy}, 0);
    check("cfg_done", {31'd0, cfg_done}, {31'd0, exp_done});
    check("cfg_error", {31'd0, cfg_error}, {31'd0, exp_err});
    check("err_index", err_index, exp_idx);
    check("tbl_addr", bus.tbl_addr, exp_addr);
    check("all_enables_seen", expq.size(), 0);
  endtask

  initial begin
    int n, e0;
    clear_tbl();
    repeat (3) @(posedge clk);
    #1 reset_check();

    cur_case = "two_writes";
    clear_tbl();
    rom[0] = 16'h3008; rom[1] = 16'h0102; resp_d[0] = 116; resp_d[1] = 116;
    start_seq(); poke_at = 50; finish_seq(5000);

    cur_case = "delay_entry";
    clear_tbl();
    rom[0] = 16'hFE05; rom[1] = 16'h1234; resp_d[1] = $urandom_range(1, 60);
    start_seq(); finish_seq(5000);

    cur_case = "retry_exhaust";
    clear_tbl();
    rom[0] = 16'h1111; resp_d[0] = 20; rom[1] = 16'h2222; fail_cnt[1] = 4;
    start_seq(); finish_seq(6000);

    cur_case = "retry_recover";
    clear_tbl();
    rom[0] = 16'hABCD; fail_cnt[0] = 2; resp_d[0] = 30;
    start_seq(); finish_seq(5000);

    cur_case = "reset";
    clear_tbl();
    rom[0] = 16'h3008; rom[1] = 16'h0102; resp_d[0] = 116; resp_d[1] = 116;
    start_seq();
    e0 = en_seen; n = 0;
    while (en_seen == e0 && n < 4000) begin @(posedge clk); #1; n++; end
    check("first_enable_seen", {31'd0, n < 4000}, 1);
    repeat (20) @(posedge clk);
    #1 reset_check();
    start_seq();
    n = 0;
    while (bus.i2c_enable !== 1'b1 && n < 4000) begin @(posedge clk); #1; n++; end
    check("issue_seen", {31'd0, n < 4000}, 1);
    reset_check();
    start_seq(); finish_seq(5000);

    cur_case = "random_mix";
    clear_tbl();
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 7))
        0: rom[i] = {8'hFE, 8'($urandom_range(1, 2))};
        1: rom[i] = 16'hFE00;
        default: begin
          rom[i] = rand_payload();
          resp_d[i] = $urandom_range(1, 60);
          fail_cnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        end
      endcase
    end
    start_seq(); finish_seq(20000);

    cur_case = "full_table";
    clear_tbl();
    for (int i = 0; i < N; i++) begin
      rom[i] = rand_payload();
      resp_d[i] = $urandom_range(1, 6);
    end
    start_seq(); finish_seq(30000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached in case %s", cur_case);
    $fatal(1, "watchdog");
  end
endmodule
